// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: parity selection and the
// transmitter's frame-sequencing states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data always presents the head word,
// so a consumer can pop and use the word in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered serial transmitter: start bit, LSB-first payload, optional parity,
// one or two stop bits; frames run back-to-back while words are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLOCKS_PER_BAUD = 868,
  parameter int      DATA_BITS       = 8,
  parameter parity_t PARITY          = PAR_NONE,
  parameter int      STOP_BITS       = 1,
  parameter int      FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          tx
);

  localparam int BAUD_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_STOP = IDX_W'(STOP_BITS - 1);

  if (CLOCKS_PER_BAUD < 2) begin : g_bad_cpb
    $error("CLOCKS_PER_BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("DATA_BITS must be within 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  state_t                state_reg,  state_next;
  logic [BAUD_W-1:0]     baud_reg,   baud_next;
  logic [IDX_W-1:0]      idx_reg,    idx_next;
  logic [DATA_BITS-1:0]  shift_reg,  shift_next;
  logic                  parity_reg, parity_next;
  logic                  tx_reg,     tx_next;
  logic                  try_pop;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  fifo_data;
  logic                  baud_done;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (valid_i),
    .wr_data (data_i),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count_o)
  );

  assign ready_o   = !fifo_full;
  assign busy_o    = (state_reg != ST_IDLE);
  assign tx        = tx_reg;
  assign baud_done = (baud_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      baud_reg   <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    try_pop     = 1'b0;
    fifo_pop    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        tx_next = 1'b1;
        try_pop = 1'b1;
      end
      ST_START: begin
        if (baud_done) begin
          state_next = ST_DATA;
          baud_next  = BAUD_LOAD;
          idx_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_next = BAUD_LOAD;
          if (idx_reg == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              state_next = ST_PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = ST_STOP;
              idx_next   = '0;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_next = ST_STOP;
          baud_next  = BAUD_LOAD;
          idx_next   = '0;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          if (idx_reg == LAST_STOP) begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
            try_pop    = 1'b1;
          end else begin
            idx_next  = idx_reg + IDX_W'(1);
            baud_next = BAUD_LOAD;
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Shared frame launch: from IDLE or straight out of the last stop bit.
    if (try_pop && !fifo_empty) begin
      fifo_pop    = 1'b1;
      state_next  = ST_START;
      baud_next   = BAUD_LOAD;
      tx_next     = 1'b0;
      shift_next  = fifo_data;
      parity_next = (^fifo_data) ^ (PARITY == PAR_ODD);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: three transmitter configurations, each with its own stimulus
// process scheduling expected frames and a monitor decoding the serial line.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  typedef struct {
    int frame;
    int start;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp, input int inst);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cfg%0d cycle %0d: got 0x%0h expected 0x%0h", name, inst, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int      CPB   = (gi == 0) ? 4 : ((gi == 1) ? 3 : 5);
    localparam int      DB    = (gi == 1) ? 7 : 8;
    localparam parity_t PAR   = (gi == 0) ? PAR_NONE : ((gi == 1) ? PAR_EVEN : PAR_ODD);
    localparam int      SB    = (gi == 1) ? 2 : 1;
    localparam int      DEPTH = 4;
    localparam int      FB    = 1 + DB + ((PAR != PAR_NONE) ? 1 : 0) + SB;
    localparam int      CW    = $clog2(DEPTH) + 1;

    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          ready;
    logic          busy;
    logic          tx;
    logic [CW-1:0] count;
    exp_t          q[$];
    int            last_end = 0;
    bit            in_frame = 1'b0;
    bit            fin = 1'b0;

    uart_tx_fifo #(
      .CLOCKS_PER_BAUD (CPB),
      .DATA_BITS       (DB),
      .PARITY          (PAR),
      .STOP_BITS       (SB),
      .FIFO_DEPTH      (DEPTH)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data),
      .valid_i (valid),
      .ready_o (ready),
      .count_o (count),
      .busy_o  (busy),
      .tx      (tx)
    );

    // Expected line pattern, bit 0 = start bit.
    function automatic int mk_frame(input logic [DB-1:0] w);
      int   f = 0;
      int   pos;
      logic p;
      for (int i = 0; i < DB; i++) f[1+i] = w[i];
      p = ^w;
      if (PAR == PAR_ODD) p = ~p;
      pos = 1 + DB;
      if (PAR != PAR_NONE) begin
        f[pos] = p;
        pos++;
      end
      for (int s = 0; s < SB; s++) f[pos+s] = 1'b1;
      return f;
    endfunction

    function automatic int model_count();
      int n = 0;
      foreach (q[i]) if (q[i].start > cyc) n++;
      return n;
    endfunction

    task automatic check_io();
      int n = model_count();
      check("count", int'(count), n, gi);
      check("ready", int'(ready), (n < DEPTH) ? 1 : 0, gi);
    endtask

    // Word will be accepted on the coming edge cyc+1; it starts one edge later or
    // when the previous frame's last stop bit ends, whichever is later.
    task automatic accept(input logic [DB-1:0] w);
      int s = (last_end > cyc + 2) ? last_end : cyc + 2;
      q.push_back('{mk_frame(w), s});
      last_end = s + FB * CPB;
    endtask

    task automatic send(input logic [DB-1:0] w);
      int guard = 0;
      valid = 1'b1;
      data  = w;
      check_io();
      while (!ready && guard < 5000) begin
        @(negedge clk);
        guard++;
        check_io();
      end
      if (ready) begin
        accept(w);
        @(negedge clk);
      end else begin
        check("send_timeout", 1, 0, gi);
      end
    endtask

    task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) begin
        check_io();
        @(negedge clk);
      end
    endtask

    task automatic drain();
      int g = 0;
      valid = 1'b0;
      while ((q.size() != 0 || in_frame || cyc < last_end) && g < 20000) begin
        @(negedge clk);
        g++;
      end
      check("drain_timeout", (g < 20000) ? 0 : 1, 0, gi);
      check("busy_idle", int'(busy), 0, gi);
      check("tx_idle", int'(tx), 1, gi);
      check_io();
    endtask

    task automatic wait_edge_before(input int e);
      while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic do_reset();
      valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      q.delete();
      last_end = 0;
      check("rst_tx", int'(tx), 1, gi);
      check("rst_busy", int'(busy), 0, gi);
      check_io();
      @(negedge clk);
      rst = 1'b0;
    endtask

    initial begin : stim
      int s0;
      @(negedge clk);
      do_reset();
      idle(2);

      if (gi == 0) begin
        send(DB'(8'hA5));
        idle(3);
      end else if (gi == 1) begin
        send(DB'(7'h55));
        idle(2);
        drain();
        send(DB'(7'h54));
        idle(2);
      end else begin
        send(DB'(8'h00));
        idle(2);
        send(DB'(8'hFF));
        idle(2);
        send(DB'(8'h01));
        idle(2);
      end
      drain();

      for (int i = 0; i < 6; i++) send(DB'($urandom));
      drain();

      // Push lands on the same edge the transmitter pops the next word.
      for (int i = 0; i < 3; i++) send(DB'($urandom));
      valid = 1'b0;
      wait_edge_before(q[q.size()-2].start);
      check_io();
      send(DB'($urandom));
      idle(2);
      drain();

      // Reset in the middle of data bit 3 with two words still buffered.
      send(DB'($urandom));
      s0 = q[0].start;
      send(DB'($urandom));
      send(DB'($urandom));
      valid = 1'b0;
      wait_edge_before(s0 + 4 * CPB + CPB / 2);
      do_reset();
      idle(FB * CPB * 2);
      drain();

      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, CPB * FB));
        send(DB'($urandom));
      end
      drain();
      fin = 1'b1;
    end

    initial begin : monitor
      exp_t cur;
      bit   have_exp = 1'b0;
      int   idx = 0;
      int   obs = 0;
      bit   bad = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          in_frame = 1'b0;
        end else begin
          if (!in_frame && tx == 1'b0) begin
            if (q.size() == 0) begin
              check("unexpected_frame", 1, 0, gi);
              have_exp = 1'b0;
            end else begin
              cur = q.pop_front();
              have_exp = 1'b1;
              check("start_edge", cyc, cur.start, gi);
            end
            in_frame = 1'b1;
            idx = 0;
            obs = 0;
            bad = 1'b0;
          end
          if (in_frame) begin
            if (idx % CPB == 0) obs[idx/CPB] = tx;
            else if (obs[idx/CPB] != tx) bad = 1'b1;
            if (!busy) bad = 1'b1;
            idx++;
            if (idx == FB * CPB) begin
              in_frame = 1'b0;
              if (have_exp) begin
                check("frame_bits", obs, cur.frame, gi);
                check("frame_hold", int'(bad), 0, gi);
              end
            end
          end
        end
      end
    end
  end

  initial begin : top
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && cyc < 90000) @(negedge clk);
    check("global_timeout", (cyc < 90000) ? 0 : 1, 0, 9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
